// File: rtl/led_frame_feeder_if.sv
// Host write port plus LED-driver pixel handshake for led_frame_feeder.
// The feeder takes the slave side; the host/driver side is the master.
interface led_frame_feeder_if #(
    parameter int NUM_LEDS    = 20,
    parameter int COLOR_WIDTH = 8
);
    localparam int CounterWidth = $clog2(NUM_LEDS);

    logic                    wr_en;
    logic [CounterWidth-1:0] wr_addr;
    logic [COLOR_WIDTH-1:0]  wr_green;
    logic [COLOR_WIDTH-1:0]  wr_red;
    logic [COLOR_WIDTH-1:0]  wr_blue;
    logic                    frame_start;
    logic [CounterWidth-1:0] led_req_in;

    logic [COLOR_WIDTH-1:0]  green_out;
    logic [COLOR_WIDTH-1:0]  red_out;
    logic [COLOR_WIDTH-1:0]  blue_out;
    logic                    color_valid_out;
    logic                    busy_out;
    logic                    frame_done_out;
    logic                    timeout_err_out;
    logic                    frame_dropped_out;

    modport master (
        output wr_en, wr_addr, wr_green, wr_red, wr_blue, frame_start, led_req_in,
        input  green_out, red_out, blue_out, color_valid_out, busy_out,
               frame_done_out, timeout_err_out, frame_dropped_out
    );

    modport slave (
        input  wr_en, wr_addr, wr_green, wr_red, wr_blue, frame_start, led_req_in,
        output green_out, red_out, blue_out, color_valid_out, busy_out,
               frame_done_out, timeout_err_out, frame_dropped_out
    );
endinterface

// File: rtl/led_frame_feeder.sv
// Double-buffered pixel store that streams one frame to an LED driver, advancing
// a pixel each time the driver's pixel counter moves on.
//
// state    | meaning
// IDLE     | no frame in flight; frame_start swaps banks and starts a frame
// FETCH    | registered read of front[pix_idx]
// ISSUE    | present pixel, pulse color_valid_out, snapshot driver counter
// WAIT_ACK | wait for the driver counter to change, or time out
module led_frame_feeder #(
    parameter int NUM_LEDS    = 20,
    parameter int COLOR_WIDTH = 8,
    parameter int ACK_TIMEOUT = 4096
) (
    input  logic              clk_in,
    input  logic              rst_in,
    led_frame_feeder_if.slave bus
);
    localparam int CounterWidth = $clog2(NUM_LEDS);
    localparam int PixelWidth   = 3 * COLOR_WIDTH;
    localparam int TimerWidth   = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
    localparam logic [CounterWidth:0]   LedCount  = (CounterWidth + 1)'(NUM_LEDS);
    localparam logic [CounterWidth-1:0] LastIdx   = CounterWidth'(NUM_LEDS - 1);
    localparam logic [TimerWidth-1:0]   TimerLast = TimerWidth'(ACK_TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, FETCH, ISSUE, WAIT_ACK} state_t;

    state_t                  state;
    logic                    bank_sel;
    logic [CounterWidth-1:0] pix_idx;
    logic [CounterWidth-1:0] ack_ref;
    logic [TimerWidth-1:0]   timer;
    logic [PixelWidth-1:0]   rd_data;
    logic [PixelWidth-1:0]   pix_mem [2][NUM_LEDS];
    logic                    wr_ok;

    assign wr_ok = bus.wr_en && ({1'b0, bus.wr_addr} < LedCount);

    // Pixel storage is deliberately left out of reset; the host repaints it before use.
    always_ff @(posedge clk_in) begin
        if (wr_ok) begin
            pix_mem[~bank_sel][bus.wr_addr] <= {bus.wr_green, bus.wr_red, bus.wr_blue};
        end
        if (state == FETCH) begin
            rd_data <= pix_mem[bank_sel][pix_idx];
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state                 <= IDLE;
            bank_sel              <= 1'b0;
            pix_idx               <= '0;
            ack_ref               <= '0;
            timer                 <= '0;
            bus.green_out         <= '0;
            bus.red_out           <= '0;
            bus.blue_out          <= '0;
            bus.color_valid_out   <= 1'b0;
            bus.busy_out          <= 1'b0;
            bus.frame_done_out    <= 1'b0;
            bus.timeout_err_out   <= 1'b0;
            bus.frame_dropped_out <= 1'b0;
        end else begin
            bus.color_valid_out   <= 1'b0;
            bus.frame_done_out    <= 1'b0;
            bus.timeout_err_out   <= 1'b0;
            bus.frame_dropped_out <= bus.frame_start && (state != IDLE);

            case (state)
                IDLE: begin
                    if (bus.frame_start) begin
                        bank_sel     <= ~bank_sel;
                        pix_idx      <= '0;
                        state        <= FETCH;
                        bus.busy_out <= 1'b1;
                    end
                end
                FETCH: begin
                    state <= ISSUE;
                end
                ISSUE: begin
                    {bus.green_out, bus.red_out, bus.blue_out} <= rd_data;
                    bus.color_valid_out <= 1'b1;
                    ack_ref             <= bus.led_req_in;
                    timer               <= '0;
                    state               <= WAIT_ACK;
                end
                WAIT_ACK: begin
                    // Any change of the driver counter, wrap included, acknowledges the
                    // pixel; it also wins over a timeout landing on the same cycle.
                    if (bus.led_req_in != ack_ref) begin
                        if (pix_idx == LastIdx) begin
                            bus.frame_done_out <= 1'b1;
                            bus.busy_out       <= 1'b0;
                            state              <= IDLE;
                        end else begin
                            pix_idx <= pix_idx + 1'b1;
                            state   <= FETCH;
                        end
                    end else if (timer == TimerLast) begin
                        bus.timeout_err_out <= 1'b1;
                        bus.busy_out        <= 1'b0;
                        state               <= IDLE;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                default: begin
                    bus.busy_out <= 1'b0;
                    state        <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_led_frame_feeder.sv
// Bench for led_frame_feeder: directed frame scenarios plus randomized traffic, all
// checked every cycle against a cycle-arithmetic reference of the frame protocol.
module tb_led_frame_feeder;
    localparam int NLED  = 20;
    localparam int CW    = 8;
    localparam int ACK_T = 4096;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    led_frame_feeder_if #(.NUM_LEDS(NLED), .COLOR_WIDTH(CW)) bus ();

    led_frame_feeder #(.NUM_LEDS(NLED), .COLOR_WIDTH(CW), .ACK_TIMEOUT(ACK_T)) dut (
        .clk_in(clk),
        .rst_in(rst_n),
        .bus   (bus)
    );

    int tests = 0;
    int errors = 0;

    // ---------------- reference model ----------------
    int          cyc = 0;
    logic [23:0] m_mem [2][NLED];
    bit          m_sel = 0, m_busy = 0, m_wait = 0;
    int          m_pix = 0, m_issue_at = 0, m_issue_edge = 0;
    logic [4:0]  m_ref = '0;
    logic [23:0] e_col = '0;
    bit          e_valid = 0, e_done = 0, e_to = 0, e_drop = 0;

    always @(posedge clk or negedge rst_n) begin : model
        bit was_busy;
        if (!rst_n) begin
            m_sel = 0; m_busy = 0; m_wait = 0; m_pix = 0;
            e_col = '0; e_valid = 0; e_done = 0; e_to = 0; e_drop = 0;
        end else begin
            cyc++;
            was_busy = m_busy;
            e_valid = 0; e_done = 0; e_to = 0; e_drop = 0;
            if (bus.wr_en && int'(bus.wr_addr) < NLED)
                m_mem[m_sel ? 0 : 1][bus.wr_addr] = {bus.wr_green, bus.wr_red, bus.wr_blue};
            if (!was_busy) begin
                if (bus.frame_start) begin
                    m_sel = !m_sel; m_busy = 1; m_pix = 0; m_wait = 0; m_issue_at = cyc + 2;
                end
            end else begin
                if (bus.frame_start) e_drop = 1;
                if (m_wait) begin
                    if (bus.led_req_in != m_ref) begin
                        m_wait = 0;
                        if (m_pix == NLED - 1) begin
                            e_done = 1; m_busy = 0;
                        end else begin
                            m_pix++; m_issue_at = cyc + 2;
                        end
                    end else if (cyc - m_issue_edge == ACK_T) begin
                        e_to = 1; m_busy = 0; m_wait = 0;
                    end
                end else if (cyc == m_issue_at) begin
                    e_valid = 1; e_col = m_mem[m_sel ? 1 : 0][m_pix];
                    m_ref = bus.led_req_in; m_wait = 1; m_issue_edge = cyc;
                end
            end
        end
    end

    always @(negedge clk) begin : compare
        tests++;
        if ({bus.green_out, bus.red_out, bus.blue_out} !== e_col || bus.color_valid_out !== e_valid ||
            bus.busy_out !== m_busy || bus.frame_done_out !== e_done || bus.timeout_err_out !== e_to ||
            bus.frame_dropped_out !== e_drop) begin
            errors++;
            $display("FAIL cycle %0d outputs: got col=%h v=%b busy=%b done=%b to=%b drop=%b, want col=%h v=%b busy=%b done=%b to=%b drop=%b",
                     cyc, {bus.green_out, bus.red_out, bus.blue_out}, bus.color_valid_out, bus.busy_out,
                     bus.frame_done_out, bus.timeout_err_out, bus.frame_dropped_out,
                     e_col, e_valid, m_busy, e_done, e_to, e_drop);
        end
    end

    // ---------------- output monitor ----------------
    logic [23:0] log_val [$];
    int          log_cyc [$];
    int          done_cnt = 0, to_cnt = 0, drop_cnt = 0, to_cyc = 0;

    always @(negedge clk) begin : monitor
        if (rst_n) begin
            if (bus.color_valid_out) begin
                log_val.push_back({bus.green_out, bus.red_out, bus.blue_out});
                log_cyc.push_back(cyc);
            end
            if (bus.frame_done_out) done_cnt++;
            if (bus.timeout_err_out) begin to_cnt++; to_cyc = cyc; end
            if (bus.frame_dropped_out) drop_cnt++;
        end
    end

    // ---------------- LED driver model ----------------
    int nack_pix = -1;
    int drv_max = 1;

    always @(negedge clk) begin : driver
        int d;
        if (rst_n && bus.color_valid_out && m_pix != nack_pix) begin
            d = (drv_max > 1) ? int'($urandom_range(drv_max, 1)) : 1;
            repeat (d) @(posedge clk);
            #1;
            bus.led_req_in = (bus.led_req_in == 5'(NLED - 1)) ? 5'd0 : bus.led_req_in + 5'd1;
        end
    end

    // ---------------- helpers ----------------
    int fs_cyc = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [23:0] p1(input int i);
        return {8'(i), 8'(8'h10 + i), 8'(8'h20 + i)};
    endfunction

    function automatic logic [23:0] p2(input int i);
        return {8'(8'h80 + i), 8'(8'h40 + 3 * i), 8'(8'hC0 - i)};
    endfunction

    task automatic write_px(input int addr, input logic [23:0] v);
        bus.wr_en = 1'b1;
        bus.wr_addr = 5'(addr);
        {bus.wr_green, bus.wr_red, bus.wr_blue} = v;
        @(posedge clk); #1;
        bus.wr_en = 1'b0;
    endtask

    task automatic pulse_fs();
        @(posedge clk); #1;
        bus.frame_start = 1'b1;
        @(posedge clk); #1;
        fs_cyc = cyc;
        bus.frame_start = 1'b0;
    endtask

    task automatic clear_log();
        log_val.delete();
        log_cyc.delete();
    endtask

    task automatic wait_end(input string name, input int d0, input int t0);
        for (int k = 0; k < 6000; k++) begin
            @(negedge clk); #1;
            if (done_cnt != d0 || to_cnt != t0) return;
        end
        check({name, "_end_timeout"}, 1, 0);
    endtask

    task automatic wait_log(input string name, input int n);
        for (int k = 0; k < 2000; k++) begin
            @(negedge clk); #1;
            if (log_val.size() >= n) return;
        end
        check({name, "_log_timeout"}, 1, 0);
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin : stim
        int d0, t0, dr0;
        bus.wr_en = 1'b0; bus.wr_addr = '0;
        bus.wr_green = '0; bus.wr_red = '0; bus.wr_blue = '0;
        bus.frame_start = 1'b0; bus.led_req_in = '0;

        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", {bus.green_out, bus.red_out, bus.blue_out, bus.color_valid_out, bus.busy_out,
                                bus.frame_done_out, bus.timeout_err_out, bus.frame_dropped_out}, 0);
        @(negedge clk); #2 rst_n = 1'b1;
        @(posedge clk); #1;

        // basic frame from bank 1
        for (int i = 0; i < NLED; i++) write_px(i, p1(i));
        clear_log(); d0 = done_cnt; t0 = to_cnt;
        pulse_fs();
        wait_end("f1", d0, t0);
        check("f1_count", log_val.size(), 20);
        for (int i = 0; i < NLED && i < log_val.size(); i++) check("f1_pixel", log_val[i], p1(i));
        if (log_cyc.size() > 1) begin
            check("f1_first_latency", log_cyc[0] - fs_cyc, 2);
            check("f1_spacing", log_cyc[1] - log_cyc[0], 4);
        end
        check("f1_done_once", done_cnt - d0, 1);
        check("f1_busy_after", bus.busy_out, 0);

        // frame_start mid-frame is dropped
        for (int i = 0; i < NLED; i++) write_px(i, p2(i));
        clear_log(); d0 = done_cnt; t0 = to_cnt;
        pulse_fs();
        wait_log("f2", 5);
        dr0 = drop_cnt;
        pulse_fs();
        wait_end("f2", d0, t0);
        check("f2_dropped", drop_cnt - dr0, 1);
        check("f2_count", log_val.size(), 20);
        for (int i = 0; i < NLED && i < log_val.size(); i++) check("f2_pixel", log_val[i], p2(i));
        check("f2_done_once", done_cnt - d0, 1);

        // back-bank write during transmit only shows in the next frame
        clear_log(); d0 = done_cnt; t0 = to_cnt;
        pulse_fs();
        wait_log("f3", 2);
        @(posedge clk); #1;
        write_px(5, 24'hFFFFFF);
        wait_end("f3", d0, t0);
        if (log_val.size() > 5) check("f3_old_pixel5", log_val[5], p1(5));
        clear_log(); d0 = done_cnt; t0 = to_cnt;
        pulse_fs();
        wait_end("f4", d0, t0);
        check("f4_count", log_val.size(), 20);
        if (log_val.size() > 5) begin
            check("f4_new_pixel5", log_val[5], 24'hFFFFFF);
            check("f4_pixel4", log_val[4], p2(4));
        end

        // pixel 3 never acknowledged
        nack_pix = 3;
        clear_log(); d0 = done_cnt; t0 = to_cnt;
        pulse_fs();
        wait_end("f5", d0, t0);
        check("to_pulse", to_cnt - t0, 1);
        check("to_no_done", done_cnt - d0, 0);
        check("to_pixels_issued", log_val.size(), 4);
        if (log_cyc.size() > 3) check("to_delay", to_cyc - log_cyc[3], ACK_T);
        check("to_busy_after", bus.busy_out, 0);
        nack_pix = -1;

        // out-of-range write leaves storage untouched
        write_px(20, 24'h123456);
        clear_log(); d0 = done_cnt; t0 = to_cnt;
        pulse_fs();
        wait_end("f6", d0, t0);
        check("f6_count", log_val.size(), 20);
        for (int i = 0; i < NLED && i < log_val.size(); i++)
            check("f6_readout", log_val[i], (i == 5) ? 24'hFFFFFF : p2(i));

        // reset during WAIT_ACK of pixel 10
        nack_pix = 10;
        clear_log();
        pulse_fs();
        wait_log("f7", 11);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid_outputs", {bus.green_out, bus.red_out, bus.blue_out, bus.color_valid_out, bus.busy_out,
                                  bus.frame_done_out, bus.timeout_err_out, bus.frame_dropped_out}, 0);
        d0 = done_cnt; t0 = to_cnt;
        @(negedge clk); #2 rst_n = 1'b1;
        nack_pix = -1;
        repeat (4) @(posedge clk);
        #1;
        check("rst_no_done", done_cnt - d0, 0);
        clear_log();
        pulse_fs();
        wait_end("f8", d0, t0);
        check("f8_count", log_val.size(), 20);
        if (log_val.size() > 10) begin
            check("f8_pixel0_bank1", log_val[0], p1(0));
            check("f8_pixel10_bank1", log_val[10], p1(10));
            check("f8_first_latency", log_cyc[0] - fs_cyc, 2);
        end
        check("f8_done_once", done_cnt - d0, 1);

        // randomized traffic
        drv_max = 3;
        for (int r = 0; r < 6; r++) begin
            for (int c = 0; c < 200; c++) begin
                bus.wr_en = ($urandom_range(2, 0) == 0);
                bus.wr_addr = 5'($urandom_range(23, 0));
                bus.wr_green = 8'($urandom);
                bus.wr_red = 8'($urandom);
                bus.wr_blue = 8'($urandom);
                bus.frame_start = ($urandom_range(39, 0) == 0);
                @(posedge clk); #1;
            end
            bus.wr_en = 1'b0;
            bus.frame_start = 1'b0;
            for (int k = 0; k < 1000 && bus.busy_out; k++) begin
                @(negedge clk); #1;
            end
            check("rand_idle", bus.busy_out, 0);
        end
        drv_max = 1;

        repeat (5) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end
endmodule

// File: doc/led_frame_feeder.md
LED_FRAME_FEEDER -- requirements
Module: led_frame_feeder

Interface
REQ-001 SHALL have parameter NUM_LEDS, default 20, meaning the number of pixels per frame.
REQ-002 SHALL have parameter COLOR_WIDTH, default 8, meaning the bits per color channel.
REQ-003 SHALL have parameter ACK_TIMEOUT, default 4096, meaning the maximum cycles to wait for consumption of a pixel.
REQ-004 SHALL have local CounterWidth = $clog2(NUM_LEDS).
REQ-005 clk_in  input  1  single clock; all logic on its rising edge.
REQ-006 rst_in  input  1  reset, asynchronous, active-low.
REQ-007 wr_en  input  1  host write strobe into the back bank.
REQ-008 wr_addr  input  CounterWidth  pixel index for the write.
REQ-009 wr_green, wr_red, wr_blue  input  COLOR_WIDTH each  pixel color to write.
REQ-010 frame_start  input  1  single-cycle pulse requesting bank swap and frame transmit.
REQ-011 led_req_in  input  CounterWidth  downstream LED-driver pixel counter (next_led_request).
REQ-012 green_out, red_out, blue_out  output  COLOR_WIDTH each  registered pixel color to the driver.
REQ-013 color_valid_out  output  1  single-cycle pulse qualifying the color outputs.
REQ-014 busy_out  output  1  high whenever state != IDLE.
REQ-015 frame_done_out  output  1  single-cycle pulse when the last pixel is acknowledged.
REQ-016 timeout_err_out  output  1  single-cycle pulse on acknowledge timeout.
REQ-017 frame_dropped_out  output  1  single-cycle pulse when frame_start arrives while busy.

Function
REQ-018 SHALL hold two banks of NUM_LEDS x 3*COLOR_WIDTH pixel storage; bank_sel selects the front (read) bank, and the host writes only to the back bank.
REQ-019 wr_en with wr_addr >= NUM_LEDS SHALL be ignored; a write takes effect the next cycle.
REQ-020 State machine SHALL have states IDLE, FETCH, ISSUE, WAIT_ACK.
REQ-021 In IDLE, frame_start SHALL toggle bank_sel, clear pix_idx to 0, and move to FETCH. A same-cycle wr_en SHALL land in the old back bank, which becomes the new front bank.
REQ-022 FETCH SHALL perform a registered read of front[pix_idx] (1-cycle latency), then move to ISSUE.
REQ-023 ISSUE SHALL drive the colors, pulse color_valid_out for exactly one cycle, capture led_req_in into ack_ref, clear the timeout counter, and move to WAIT_ACK.
REQ-024 WAIT_ACK: led_req_in != ack_ref is the acknowledge.
REQ-025 On acknowledge with pix_idx < NUM_LEDS-1, SHALL increment pix_idx and move to FETCH.
REQ-026 On acknowledge with pix_idx == NUM_LEDS-1, SHALL pulse frame_done_out and move to IDLE.
REQ-027 Frame latency: color_valid_out SHALL occur 2 cycles after frame_start is sampled; each subsequent pixel issues 2 cycles after its predecessor's acknowledge.
REQ-028 The timeout counter SHALL count WAIT_ACK cycles. If it reaches ACK_TIMEOUT-1 without an acknowledge, SHALL pulse timeout_err_out and go to IDLE without frame_done_out; bank_sel is unchanged.
REQ-029 Acknowledge and timeout in the same cycle SHALL be treated as an acknowledge.
REQ-030 frame_start outside IDLE SHALL be ignored (no swap) and SHALL pulse frame_dropped_out.
REQ-031 led_req_in wrap from NUM_LEDS-1 to 0 SHALL count as an acknowledge (inequality test only).
REQ-032 Color outputs SHALL hold their last issued value between pulses.

Reset
REQ-033 On rst_in low, SHALL asynchronously set state=IDLE, bank_sel=0, pix_idx=0, timer=0, and all outputs to 0.
REQ-034 Pixel storage SHALL NOT be reset.
REQ-035 Reset asserted mid-frame SHALL abort the frame with no frame_done_out after release.
REQ-036 After release, the first frame_start SHALL be accepted normally.

Verification
REQ-037 Write pixels 0..19 of the back bank with G=idx, R=0x10+idx, B=0x20+idx, then frame_start, with a driver model that increments led_req_in 1 cycle after each color_valid_out -> 20 pulses carrying exact values in order, first pulse 2 cycles after frame_start, frame_done_out once.
REQ-038 frame_start mid-frame -> frame_dropped_out=1 for 1 cycle, transmission continues from the current bank, pixel order intact.
REQ-039 Driver model never acknowledges pixel 3 -> timeout_err_out exactly ACK_TIMEOUT cycles after the 4th color_valid_out, busy_out=0, no frame_done_out.
REQ-040 Write pixel 5=0xFFFFFF to the back bank during frame transmit, then frame_start -> the current frame shows the old pixel 5, the next frame shows 0xFFFFFF.
REQ-041 rst_in low during WAIT_ACK of pixel 10 -> outputs 0 immediately; after release plus frame_start, the frame restarts at pixel 0 from bank 1.
REQ-042 wr_en with wr_addr=20 (NUM_LEDS=20) -> no storage change, verified by a full-frame readout.
